// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, derived depth and occupancy-class encoding for the FIFO control path
package fifo_pkg;
  localparam int ADDR_WIDTH_DEF  = 4;
  localparam int BUS_SIZE_DEF    = 4;
  localparam int MEM_LENGTH_DEF  = 1 << ADDR_WIDTH_DEF;
  localparam int UMBRAL_ALTO_DEF = 12;
  localparam int UMBRAL_BAJO_DEF = 4;
  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} fifo_state_e;
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping W-bit pointer that advances by one when en is high
module fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         en,
  output logic [W-1:0] ptr
);
  logic [W-1:0] ptr_q, ptr_d;
  always_comb ptr_d = en ? ptr_q + 1'b1 : ptr_q;
  always_ff @(posedge clk) ptr_q <= reset_L ? ptr_d : '0;
  assign ptr = ptr_q;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: push/pop front end for the memoria dual-port RAM with occupancy, status and sticky error flags
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int BUS_SIZE   = BUS_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [BUS_SIZE-1:0]   data_in,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  input  logic [BUS_SIZE-1:0]   mem_data_out,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addressW,
  output logic [ADDR_WIDTH-1:0] mem_addressR,
  output logic [BUS_SIZE-1:0]   mem_data_in,
  output logic [BUS_SIZE-1:0]   data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error_overflow,
  output logic                  error_underflow
);
  localparam int MEM_LENGTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(MEM_LENGTH);
  fifo_state_e state_q, state_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d, push_ok, pop_ok;
  always_comb begin
    push_ok = reset_L & push & ~full;
    pop_ok  = reset_L & pop & ~empty;
    count_d = count_q + {{ADDR_WIDTH{1'b0}}, push_ok} - {{ADDR_WIDTH{1'b0}}, pop_ok};
    state_d = count_d == '0 ? ST_EMPTY : count_d == FULL_CNT ? ST_FULL : ST_PARTIAL;
    valid_d = pop_ok;
    ovf_d   = ovf_q | (push & full);
    unf_d   = unf_q | (pop & empty);
  end
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  fifo_ptr #(.W(ADDR_WIDTH)) u_wr (.clk(clk), .reset_L(reset_L), .en(push_ok), .ptr(mem_addressW));
  fifo_ptr #(.W(ADDR_WIDTH)) u_rd (.clk(clk), .reset_L(reset_L), .en(pop_ok), .ptr(mem_addressR));
  assign mem_write       = push_ok;
  assign mem_read        = pop_ok;
  assign mem_data_in     = data_in;
  assign data_out        = mem_data_out;
  assign valid_out       = valid_q;
  assign fifo_count      = count_q;
  assign full            = state_q == ST_FULL;
  assign empty           = state_q == ST_EMPTY;
  assign almost_full     = count_q >= umbral_alto;
  assign almost_empty    = count_q <= umbral_bajo;
  assign error_overflow  = ovf_q;
  assign error_underflow = unf_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed plus randomized check of fifo_ctrl against a queue-based FIFO model with an emulated memoria
module tb_fifo_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_L, push, pop;
  logic [3:0] data_in, mem_data_out, mem_data_in, data_out, mem_addressW, mem_addressR;
  logic [4:0] umbral_alto, umbral_bajo, fifo_count;
  logic mem_write, mem_read, valid_out, full, empty, almost_full, almost_empty;
  logic error_overflow, error_underflow;
  logic [3:0] mem [16];
  fifo_ctrl #(.ADDR_WIDTH(4), .BUS_SIZE(4)) dut (
    .clk(clk), .reset_L(reset_L), .push(push), .pop(pop), .data_in(data_in),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo), .mem_data_out(mem_data_out),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addressW(mem_addressW),
    .mem_addressR(mem_addressR), .mem_data_in(mem_data_in), .data_out(data_out),
    .valid_out(valid_out), .fifo_count(fifo_count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .error_overflow(error_overflow), .error_underflow(error_underflow)
  );
  always @(posedge clk) begin
    if (mem_write) mem[mem_addressW] <= mem_data_in;
    if (mem_read) mem_data_out <= mem[mem_addressR];
  end
  int vectors = 0, miscompares = 0;
  logic [3:0] qd[$];
  int wp = 0, rp = 0;
  bit ovf = 0, unf = 0, ev = 0;
  logic [3:0] ed = '0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step(input bit rl, input bit pu, input bit po, input logic [3:0] d);
    bit full_m, empty_m, wok, rok;
    reset_L = rl; push = pu; pop = po; data_in = d;
    #2;
    full_m  = qd.size() == 16;
    empty_m = qd.size() == 0;
    wok = rl && pu && !full_m;
    rok = rl && po && !empty_m;
    chk("mem_write", mem_write, wok);
    chk("mem_read", mem_read, rok);
    if (wok) begin
      chk("mem_addressW", mem_addressW, wp);
      chk("mem_data_in", mem_data_in, d);
    end
    if (rok) chk("mem_addressR", mem_addressR, rp);
    chk("fifo_count", fifo_count, qd.size());
    chk("full", full, full_m);
    chk("empty", empty, empty_m);
    chk("almost_full", almost_full, qd.size() >= int'(umbral_alto));
    chk("almost_empty", almost_empty, qd.size() <= int'(umbral_bajo));
    chk("valid_out", valid_out, ev);
    if (ev) chk("data_out", data_out, ed);
    chk("error_overflow", error_overflow, ovf);
    chk("error_underflow", error_underflow, unf);
    @(posedge clk);
    #1;
    if (!rl) begin
      qd.delete(); wp = 0; rp = 0; ovf = 0; unf = 0; ev = 0;
    end else begin
      if (pu && full_m) ovf = 1;
      if (po && empty_m) unf = 1;
      ev = rok;
      if (rok) ed = qd.pop_front();
      if (wok) qd.push_back(d);
      wp = (wp + int'(wok)) % 16;
      rp = (rp + int'(rok)) % 16;
    end
  endtask
  initial begin
    reset_L = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    umbral_alto = 5'd12; umbral_bajo = 5'd4;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("rst_empty", empty, 1);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_valid", valid_out, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 4'h1);
    step(1, 1, 0, 4'h2);
    step(1, 1, 0, 4'h3);
    chk("t2_wp_model", wp, 3);
    step(1, 0, 1, 0);
    chk("t2_first_pop", data_out, 4'h1);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    chk("t2_last_pop", data_out, 4'h3);
    step(1, 0, 0, 0);
    chk("t2_empty", empty, 1);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0, 4'(i));
      if (i == 11) chk("t3_almost_full_at12", almost_full, 1);
    end
    chk("t3_full", full, 1);
    chk("t3_count", fifo_count, 16);
    step(1, 1, 0, 4'hA);
    chk("t3_ovf", error_overflow, 1);
    step(1, 1, 1, 4'h5);
    chk("t4_count15", fifo_count, 15);
    chk("t4_ovf_holds", error_overflow, 1);
    step(1, 1, 1, 4'h6);
    chk("t4_count_stays", fifo_count, 15);
    for (int i = 0; i < 15; i++) step(1, 0, 1, 0);
    chk("t5_empty_model", qd.size(), 0);
    step(1, 1, 1, 4'h7);
    chk("t5_unf", error_underflow, 1);
    chk("t5_count", fifo_count, 1);
    chk("t5_valid", valid_out, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 4'(i + 8));
    chk("t6_count8", fifo_count, 8);
    step(0, 0, 1, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_valid", valid_out, 0);
    chk("t6_ovf", error_overflow, 0);
    chk("t6_unf", error_underflow, 0);
    reset_L = 1'b1; push = 1'b1; #1;
    chk("t6_addrW", mem_addressW, 0);
    step(1, 1, 0, 4'h9);
    for (int i = 0; i < 3000; i++) begin
      int ph = (i / 150) % 3;
      int pp = ph == 0 ? 80 : ph == 1 ? 20 : 50;
      int qp = ph == 0 ? 20 : ph == 1 ? 80 : 50;
      if (i % 400 == 0) begin
        umbral_alto = 5'($urandom_range(0, 16));
        umbral_bajo = 5'($urandom_range(0, 16));
      end
      step($urandom_range(0, 299) != 0, $urandom_range(0, 99) < pp,
           $urandom_range(0, 99) < qp, 4'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
